bcd_4d_down_cnt: RTL and testbench
==================================

# bcd_4d_down_cnt

Loadable 4-digit BCD down counter (countdown timer) with start/stop control, zero detection, a terminal-count pulse and optional auto-reload. It is the counting-down counterpart of the BCD up counter. It feeds BCD digits directly to the display path. It also gives the control logic a one-cycle `done` event when the count expires.

## Interface

Parameters:
- `DIGITS`, default 4: number of BCD digits. All BCD buses are `4*DIGITS` bits wide.

Ports:
- `clk`, input, 1: sole clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `load`, input, 1: load `d` into the counter and the reload register.
- `d`, input, `4*DIGITS`: BCD load value; digit 0 in `[3:0]`.
- `start`, input, 1: begin counting from IDLE.
- `stop`, input, 1: abort counting and hold the current value.
- `en`, input, 1: count-enable tick. One decrement per cycle with `en`=1 in RUN.
- `auto_reload`, input, 1: on expiry, reload the stored value and keep running.
- `bcd`, output, `4*DIGITS`: current count.
- `zero`, output, 1: `bcd` is all zeros. Registered with `bcd`.
- `busy`, output, 1: state is RUN or RELOAD.
- `done`, output, 1: one-cycle pulse when the count reaches zero.
- `load_err`, output, 1: one-cycle pulse when a load is rejected for an invalid digit.

## Operation

- **States:** IDLE, RUN, RELOAD.
- **Reset values:** `bcd`=0, reload register=0, state IDLE, `zero`=1, `busy`=0, `done`=0, `load_err`=0.
- **Priority per cycle:** reset > load > stop > start > en.
- **Load:**
  - If every digit of `d` is ≤9, then `bcd` and the reload register take `d`, and the state goes to IDLE from any state.
  - If any digit is >9, then `bcd`, the reload register and the state are unchanged, and `load_err`=1 for one cycle.
- **IDLE:**
  - `start`=1 with `bcd`≠0 goes to RUN.
  - `start` with `bcd`=0 is ignored: no `done`, no `busy`.
  - `en` is ignored.
- **RUN:**
  - With `en`=1, decrement by one with a borrow chain. A digit at 0 becomes 9 and borrows from the next digit. A digit >0 decrements and stops the chain.
  - With `en`=0, hold.
  - `stop`=1 goes to IDLE with `bcd` held.
  - `start` in RUN is ignored.
- **Expiry:** a decrement that produces all zeros asserts `done` on the same edge that `bcd` becomes 0.
  - Next state is RELOAD if `auto_reload`=1 and the reload register ≠0.
  - Otherwise next state is IDLE.
- **RELOAD:** for one cycle regardless of `en`, `bcd` takes the reload register, then the state returns to RUN.
  - `stop` in RELOAD goes to IDLE with `bcd` still 0.
- **Underflow:** 0000 never decrements to 9999. Counting only occurs in RUN, and RUN is never entered or kept at zero.

## Timing

- All outputs are registered. `bcd` changes on the edge after the qualifying `en` cycle.
- `done` is high exactly one cycle, aligned with the first cycle `bcd`=0. `zero` rises in that same cycle.
- `busy` rises one cycle after `start` is sampled. It falls in the cycle `bcd` first reads 0 when no reload follows.
- Auto-reload period with `en` held high and reload value N: N+1 cycles between `done` pulses (N decrements plus 1 RELOAD cycle).
- `load` during RUN takes effect next edge. The counter stops in IDLE with the new value, and no `done` is produced even if the old count was 0001.
- `load` and `en` in the same cycle: the load wins and no decrement occurs.
- Reset mid-RUN: the next cycle shows all reset values. A pending `done` is suppressed.

## Structure

- Shared package holds:
  - `BCD_DIGIT_W`=4 and `BCD_MAX`=4'd9.
  - The state enum type {IDLE, RUN, RELOAD}.
  - An `is_bcd_valid` digit-check function. The encoder/display blocks use it too.
- One sub-module: `bcd_digit_dn`, instantiated `DIGITS` times in a generate loop and chained via borrow.
  - Inputs: `dec`, `ld`, `ld_val`.
  - Outputs: `q[3:0]`, `borrow_out` (asserted when `q`=0 and `dec`=1), `is_zero`.
- The top holds the FSM, the reload register, load validation and the `done`/`load_err` pulse generation.

## Test plan

- Reset, then load 0x0003, then `start` with `en`=1 → `bcd` goes 0003, 0002, 0001, 0000. `done`=1 only in the 0000 cycle, `zero`=1, `busy`=0 afterward.
- Load 0x1000, `start`, one `en` tick → `bcd`=0x0999 (borrow across three digits). `stop` then holds 0x0999 with `busy`=0.
- Load 0x0002 with `auto_reload`=1 and `en` held high → `bcd` sequence 2,1,0,2,1,0… with `done` every 3 cycles. `busy` stays 1.
- Load 0x12A4 → `load_err` pulses once. `bcd` and the reload register keep their prior values (e.g. 0x0050).
- `start` with `bcd`=0 → stays IDLE, no `done`. `load` 0x0005 asserted together with `en` in RUN at `bcd`=0x0001 → `bcd`=0x0005, state IDLE, no `done`.
- Assert `reset` while in RUN at `bcd`=0x0001 with `en`=1 → next cycle `bcd`=0, `zero`=1, `done`=0, `busy`=0.

Source files
------------

// File: rtl/bcd_4d_down_cnt_pkg.sv
// Shared definitions for the BCD down counter and its neighbours on the
// display path (encoder/display blocks reuse the digit check).
package bcd_4d_down_cnt_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RELOAD = 2'd2
  } state_t;

  // True when a nibble holds a legal decimal digit (0..9).
  function automatic logic is_bcd_valid(input logic [BCD_DIGIT_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD digit of the down counter. Load has priority over decrement;
// a digit at 0 wraps to 9 and raises borrow_out for the next digit.
module bcd_digit_dn
  import bcd_4d_down_cnt_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dec,
  input  logic                   ld,
  input  logic [BCD_DIGIT_W-1:0] ld_val,
  output logic [BCD_DIGIT_W-1:0] q,
  output logic                   borrow_out,
  output logic                   is_zero
);

  assign is_zero    = (q == '0);
  assign borrow_out = dec & is_zero;

  // Digit register: reset, then load, then decrement with 0 -> 9 wrap.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (ld)
      q <= ld_val;
    else if (dec)
      q <= is_zero ? BCD_MAX : q - 4'd1;
  end

endmodule

// File: rtl/bcd_4d_down_cnt.sv
// Loadable BCD countdown timer: start/stop control, zero flag, one-cycle
// done pulse on expiry, optional auto-reload from the last loaded value.
module bcd_4d_down_cnt
  import bcd_4d_down_cnt_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] d,
  input  logic                start,
  input  logic                stop,
  input  logic                en,
  input  logic                auto_reload,
  output logic [4*DIGITS-1:0] bcd,
  output logic                zero,
  output logic                busy,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  state_t            state, state_nxt;
  logic [W-1:0]      reload_q;
  logic [W-1:0]      ld_val;
  logic [DIGITS-1:0] dec;
  logic [DIGITS-1:0] borrow;
  logic [DIGITS-1:0] digit_zero;
  logic              d_valid;
  logic              ld_ok, ld_bad, ctrl_free;
  logic              do_reload, count_en, expire, underflow, digit_ld;

  // Load value is accepted only if every nibble is a decimal digit.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    d_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (!is_bcd_valid(d[BCD_DIGIT_W*i +: BCD_DIGIT_W])) d_valid = 1'b0;
  end

  assign ld_ok     = load & d_valid;
  assign ld_bad    = load & ~d_valid;
  assign ctrl_free = ~load & ~stop;
  assign do_reload = ctrl_free & (state == RELOAD);
  assign count_en  = ctrl_free & (state == RUN) & en;
  assign expire    = count_en & (bcd == W'(1));
  // A borrow out of the top digit would mean 0000 -> 9999; RUN is never
  // held at zero, but if it ever happened the digits are forced back to 0.
  assign underflow = borrow[DIGITS-1];
  assign digit_ld  = ld_ok | do_reload | underflow;
  assign ld_val    = ld_ok ? d : (do_reload ? reload_q : '0);

  assign zero = &digit_zero;
  assign busy = (state != IDLE);

  // Digit chain: digit 0 decrements on count_en, higher digits on borrow.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign dec[g] = count_en;
    end else begin : g_upper
      assign dec[g] = borrow[g-1];
    end
    bcd_digit_dn u_digit (
      .clk        (clk),
      .reset      (reset),
      .dec        (dec[g]),
      .ld         (digit_ld),
      .ld_val     (ld_val[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .q          (bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .borrow_out (borrow[g]),
      .is_zero    (digit_zero[g])
    );
  end

  // Next-state logic: load > stop > start > en; a rejected load freezes all.
  always_comb begin
    state_nxt = state;
    if (ld_ok) begin
      state_nxt = IDLE;
    end else if (!load) begin
      if (stop) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE:    if (start && !zero) state_nxt = RUN;
          RUN: begin
            if (underflow)
              state_nxt = IDLE;
            else if (expire)
              state_nxt = (auto_reload && reload_q != '0) ? RELOAD : IDLE;
          end
          RELOAD:  state_nxt = RUN;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // State register, reload value and the registered one-cycle pulses.
  // NOTE: the reload register is reset explicitly because its value is
  // observable (auto-reload after reset must reload 0, i.e. not reload).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      reload_q <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      if (ld_ok) reload_q <= d;
      done     <= expire;
      load_err <= ld_bad;
    end
  end

endmodule

// File: tb/tb_bcd_4d_down_cnt.sv
// Directed bench for bcd_4d_down_cnt: an integer-valued model of the timer
// is compared against the DUT every cycle, and literal expectations pin the
// model at the interesting points of each scenario.
module tb_bcd_4d_down_cnt;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] d = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        en = 1'b0;
  logic        auto_reload = 1'b0;
  logic [15:0] bcd;
  logic        zero, busy, done, load_err;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  bcd_4d_down_cnt #(.DIGITS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .d           (d),
    .start       (start),
    .stop        (stop),
    .en          (en),
    .auto_reload (auto_reload),
    .bcd         (bcd),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .load_err    (load_err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v, m;
    v = 0;
    m = 1;
    for (int i = 0; i < 4; i++) begin
      v += int'(b[4*i +: 4]) * m;
      m *= 10;
    end
    return v;
  endfunction

  function automatic bit all_digits_ok(input logic [15:0] b);
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural model: count held as a plain integer.
  int m_val = 0;
  int m_rel = 0;
  bit m_run = 0;
  bit m_reloading = 0;
  bit m_done = 0;
  bit m_err = 0;

  always @(posedge clk) begin
    m_done = 0;
    m_err  = 0;
    if (reset) begin
      m_val = 0; m_rel = 0; m_run = 0; m_reloading = 0;
    end else if (load) begin
      if (all_digits_ok(d)) begin
        m_val = from_bcd(d); m_rel = m_val; m_run = 0; m_reloading = 0;
      end else begin
        m_err = 1;
      end
    end else if (stop) begin
      m_run = 0; m_reloading = 0;
    end else if (m_reloading) begin
      m_val = m_rel; m_reloading = 0; m_run = 1;
    end else if (m_run) begin
      if (en) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1;
          m_run  = 0;
          if (auto_reload && m_rel != 0) m_reloading = 1;
        end
      end
    end else if (start && m_val != 0) begin
      m_run = 1;
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_bcd", bcd, to_bcd(m_val));
      check("model_zero", 16'(zero), 16'(m_val == 0));
      check("model_busy", 16'(busy), 16'(m_run | m_reloading));
      check("model_done", 16'(done), 16'(m_done));
      check("model_load_err", 16'(load_err), 16'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] b, input logic z,
                            input logic bs, input logic dn, input logic le);
    check({tag, "_bcd"}, bcd, b);
    check({tag, "_zero"}, 16'(zero), 16'(z));
    check({tag, "_busy"}, 16'(busy), 16'(bs));
    check({tag, "_done"}, 16'(done), 16'(dn));
    check({tag, "_load_err"}, 16'(load_err), 16'(le));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] auto_seq [8];

  initial begin
    auto_seq = '{16'h0001, 16'h0000, 16'h0002, 16'h0001,
                 16'h0000, 16'h0002, 16'h0001, 16'h0000};

    // Reset
    tick(); tick();
    chk_on = 1'b1;
    expect_out("reset", 16'h0000, 1, 0, 0, 0);
    reset = 1'b0;

    // Load 3, count to zero
    load = 1; d = 16'h0003; tick(); load = 0;
    expect_out("ld3", 16'h0003, 0, 0, 0, 0);
    start = 1; en = 1; tick(); start = 0;
    expect_out("run3", 16'h0003, 0, 1, 0, 0);
    tick(); expect_out("cnt2", 16'h0002, 0, 1, 0, 0);
    tick(); expect_out("cnt1", 16'h0001, 0, 1, 0, 0);
    tick(); expect_out("cnt0", 16'h0000, 1, 0, 1, 0);
    tick(); expect_out("after0", 16'h0000, 1, 0, 0, 0);
    en = 0;

    // Borrow across three digits, hold, stop
    load = 1; d = 16'h1000; tick(); load = 0;
    start = 1; tick(); start = 0;
    expect_out("run1000", 16'h1000, 0, 1, 0, 0);
    en = 1; tick(); en = 0;
    expect_out("borrow", 16'h0999, 0, 1, 0, 0);
    tick(); expect_out("hold", 16'h0999, 0, 1, 0, 0);
    stop = 1; tick(); stop = 0;
    expect_out("stop", 16'h0999, 0, 0, 0, 0);

    // Auto-reload with value 2: done every 3 cycles, then stop in RELOAD
    load = 1; d = 16'h0002; auto_reload = 1; tick(); load = 0;
    start = 1; en = 1; tick(); start = 0;
    expect_out("ar_start", 16'h0002, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("ar%0d", i), auto_seq[i], auto_seq[i] == 16'h0000,
                 1, auto_seq[i] == 16'h0000, 0);
    end
    stop = 1; tick(); stop = 0;
    expect_out("ar_stop", 16'h0000, 1, 0, 0, 0);
    en = 0; auto_reload = 0;

    // Invalid load is rejected; reload register keeps 0050
    load = 1; d = 16'h0050; tick();
    d = 16'h12A4; tick(); load = 0;
    expect_out("bad_ld", 16'h0050, 0, 0, 0, 1);
    tick(); expect_out("bad_ld_after", 16'h0050, 0, 0, 0, 0);
    auto_reload = 1; en = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 49; i++) tick();
    expect_out("rel50_one", 16'h0001, 0, 1, 0, 0);
    tick(); expect_out("rel50_zero", 16'h0000, 1, 1, 1, 0);
    tick(); expect_out("rel50_reload", 16'h0050, 0, 1, 0, 0);
    stop = 1; en = 0; tick(); stop = 0; auto_reload = 0;
    expect_out("rel50_stop", 16'h0050, 0, 0, 0, 0);

    // Start at zero is ignored
    load = 1; d = 16'h0000; tick(); load = 0;
    start = 1; tick(); start = 0;
    expect_out("start0", 16'h0000, 1, 0, 0, 0);

    // Load beats en in RUN at 0001: no done
    load = 1; d = 16'h0002; tick(); load = 0;
    start = 1; en = 1; tick(); start = 0;
    tick(); expect_out("pre_ld", 16'h0001, 0, 1, 0, 0);
    load = 1; d = 16'h0005; tick(); load = 0;
    expect_out("ld_wins", 16'h0005, 0, 0, 0, 0);
    tick(); expect_out("ld_idle", 16'h0005, 0, 0, 0, 0);
    en = 0;

    // Reset mid-RUN at 0001 suppresses done
    load = 1; d = 16'h0001; tick(); load = 0;
    start = 1; en = 1; tick(); start = 0;
    expect_out("pre_rst", 16'h0001, 0, 1, 0, 0);
    reset = 1; tick(); reset = 0;
    expect_out("mid_rst", 16'h0000, 1, 0, 0, 0);
    tick(); expect_out("post_rst", 16'h0000, 1, 0, 0, 0);
    en = 0;

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
